subtractor_pipe: RTL and testbench
==================================

Name: subtractor_pipe

Overview:
- Inverse companion to the team's combinational N-bit adder.
- Given a truncated sum and one operand, recovers the other operand: opa = sum - opb mod 2^WIDTH.
- Flags when the original addition wrapped. This is the carry the adder discards; here it appears as a borrow.
- Two-stage registered pipeline with valid/ready handshakes on both sides. Sits downstream of adder result streams in checker/reconstruction paths.

Parameters:
- WIDTH, 8, width of sum_i, opb_i and opa_o.
- CNT_WIDTH, 16, width of the completed-transaction counter.

Ports:
- clk_i  input  1  rising-edge clock
- arst_ni  input  1  asynchronous active-low reset
- flush_i  input  1  synchronous clear of all pipeline contents
- in_valid_i  input  1  sum_i/opb_i valid
- in_ready_o  output  1  block accepts input this cycle
- sum_i  input  WIDTH  truncated sum
- opb_i  input  WIDTH  known operand
- out_valid_o  output  1  opa_o/borrow_o valid
- out_ready_i  input  1  consumer accepts output
- opa_o  output  WIDTH  recovered operand
- borrow_o  output  1  1 when sum_i < opb_i (unsigned), i.e. the original add carried out
- txn_count_o  output  CNT_WIDTH  number of completed output handshakes

Behaviour:
- Reset (arst_ni=0, asynchronous):
  - Both stage valid flags and data registers clear to 0.
  - out_valid_o=0, opa_o=0, borrow_o=0, txn_count_o=0.
  - in_ready_o=1 once reset deasserts.
- Handshakes:
  - Input transfer when in_valid_i & in_ready_o; output transfer when out_valid_o & out_ready_i.
  - Stage 1 (S1) registers sum_i and opb_i. Stage 2 (S2) registers the subtraction result.
  - Arithmetic: compute {borrow, diff} = {1'b0,sum} - {1'b0,opb} in WIDTH+1 bits. borrow = MSB; opa_o = low WIDTH bits.
- Advance rules:
  - S2 may load when !s2_valid | out_ready_i.
  - S1 advances into S2 when s1_valid and S2 may load.
  - in_ready_o = !s1_valid | (S2 may load). This is combinational from out_ready_i and is intentional; no bubble cycles.
- Latency and throughput:
  - Latency: input accepted at edge N gives out_valid_o=1 after edge N+1 (2-cycle latency) when not stalled.
  - Throughput: 1 transfer/cycle with out_ready_i held high.
- Stall: while out_valid_o & !out_ready_i, opa_o and borrow_o hold stable. S1 holds its data. in_ready_o=0 when S1 is also full.
- txn_count_o increments by 1 on each output transfer and wraps from 2^CNT_WIDTH-1 to 0. It is not cleared by flush_i.
- flush_i=1: at the next edge both valid flags clear; in_ready_o is forced 0 during that cycle. An input presented during flush is dropped, and no output transfer occurs in the flush cycle.
- Boundary conditions:
  - Simultaneous input and output transfer with both stages full: S2 takes S1, S1 takes the new input, and no data is lost.
  - Reset mid-stream discards all in-flight data immediately.

Decomposition:
- Shared package adder_pkg:
  - Default WIDTH constant.
  - Typedef for the S1 payload struct {sum, opb}.
  - Typedef for the S2 payload struct {opa, borrow}.
- One natural sub-module: pipe_reg_slice, a parameterised valid/ready register slice with flush. It is instantiated twice, with the subtract logic placed between the two instances.

Test Plan:
- Basic: WIDTH=8, sum_i=0x0A, opb_i=0x03, out_ready_i=1 → two cycles later opa_o=0x07, borrow_o=0, txn_count_o=1.
- Wrap: sum_i=0x02, opb_i=0x05 → opa_o=0xFD, borrow_o=1. Also sum_i=0xFF, opb_i=0xFF → opa_o=0x00, borrow_o=0.
- Back-to-back: 16 consecutive inputs (sum_i=k, opb_i=1, k=0..15) with out_ready_i=1 → 16 outputs on 16 consecutive cycles, in order, opa_o=k-1 mod 256. in_ready_o never drops.
- Backpressure: hold out_ready_i=0 for 5 cycles while in_valid_i=1 → exactly 2 inputs accepted, then in_ready_o=0. opa_o stays stable. On release, outputs drain in order with nothing lost or duplicated.
- Flush/reset: 2 in-flight items, then assert flush_i one cycle → out_valid_o=0 next cycle and txn_count_o unchanged. Repeat using arst_ni low mid-stream → all outputs go to 0 asynchronously and txn_count_o=0.
- Counter wrap: CNT_WIDTH=4, 17 output transfers → txn_count_o=1.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types for the adder family: default operand width and the payloads
// carried between the subtractor pipeline stages.
package adder_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] sum;
        logic [DEF_WIDTH-1:0] opb;
    } s1_payload_t;

    typedef struct packed {
        logic                 borrow;
        logic [DEF_WIDTH-1:0] opa;
    } s2_payload_t;

endpackage

// File: rtl/subtractor_pipe_if.sv
// Stream interface of the subtractor pipeline: input {sum, opb} stream,
// output {opa, borrow} stream and the completed-transfer counter.
interface subtractor_pipe_if #(
    parameter int unsigned WIDTH     = adder_pkg::DEF_WIDTH,
    parameter int unsigned CNT_WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     sum;
    logic [WIDTH-1:0]     opb;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     opa;
    logic                 borrow;
    logic [CNT_WIDTH-1:0] txn_count;

    modport master (
        output in_valid, sum, opb, out_ready,
        input  in_ready, out_valid, opa, borrow, txn_count
    );

    modport slave (
        input  in_valid, sum, opb, out_ready,
        output in_ready, out_valid, opa, borrow, txn_count
    );
endinterface

// File: rtl/pipe_reg_slice.sv
// Valid/ready register slice with synchronous flush. Accepts a new word in the
// same cycle the held word leaves, so a chain of slices runs at full rate.
module pipe_reg_slice #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              arst_ni,
    input  logic              flush_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic              load;

    assign load      = !valid_q || out_ready;
    assign in_ready  = load && !flush_i;
    // A flushed word is never offered downstream, so no transfer can
    // complete in the flush cycle.
    assign out_valid = valid_q && !flush_i;
    assign out_data  = data_q;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= in_data;
            end
        end
    end
endmodule

// File: rtl/subtractor_pipe.sv
// Recovers the other adder operand from a truncated sum: opa = sum - opb,
// with borrow marking that the original add carried out. Two register slices.
module subtractor_pipe
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic clk_i,
    input  logic arst_ni,
    input  logic flush_i,
    subtractor_pipe_if.slave bus
);
    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] opb;
    } s1_t;

    typedef struct packed {
        logic             borrow;
        logic [WIDTH-1:0] opa;
    } s2_t;

    s1_t                  s1_in;
    s1_t                  s1_out;
    s2_t                  s2_in;
    s2_t                  s2_out;
    logic                 s1_valid;
    logic                 s2_ready;
    logic [WIDTH:0]       diff_ext;
    logic [CNT_WIDTH-1:0] txn_count_q;

    assign s1_in = '{sum: bus.sum, opb: bus.opb};

    pipe_reg_slice #(.DATA_W($bits(s1_t))) u_s1 (
        .clk_i     (clk_i),
        .arst_ni   (arst_ni),
        .flush_i   (flush_i),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (s1_in),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_out)
    );

    // One extra bit catches the borrow that the truncating adder dropped.
    assign diff_ext = {1'b0, s1_out.sum} - {1'b0, s1_out.opb};
    assign s2_in    = '{borrow: diff_ext[WIDTH], opa: diff_ext[WIDTH-1:0]};

    pipe_reg_slice #(.DATA_W($bits(s2_t))) u_s2 (
        .clk_i     (clk_i),
        .arst_ni   (arst_ni),
        .flush_i   (flush_i),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   (s2_in),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (s2_out)
    );

    assign bus.opa    = s2_out.opa;
    assign bus.borrow = s2_out.borrow;

    // Survives flush on purpose; only reset clears the transfer count.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            txn_count_q <= '0;
        end else if (bus.out_valid && bus.out_ready) begin
            txn_count_q <= txn_count_q + CNT_WIDTH'(1);
        end
    end

    assign bus.txn_count = txn_count_q;
endmodule

// File: tb/tb_subtractor_pipe.sv
// Bench for subtractor_pipe: queue model of in-flight items checked every
// cycle, plus directed scenarios with literal expectations.
module tb_subtractor_pipe;
    import adder_pkg::*;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic arst_ni;
    logic flush;

    subtractor_pipe_if #(.WIDTH(8), .CNT_WIDTH(CW)) bus ();

    subtractor_pipe #(.WIDTH(8), .CNT_WIDTH(CW)) dut (
        .clk_i   (clk),
        .arst_ni (arst_ni),
        .flush_i (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        s1_payload_t p;
        int          stamp;
    } item_t;

    item_t          q[$];
    logic [CW-1:0]  mcnt = '0;
    int             cyc = 0;
    int             n_vec = 0;
    int             n_fail = 0;
    int             out_seen = 0;
    int             first_out = -1;
    int             last_out = -1;
    int             in_seen = 0;
    int             ready_drops = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: an item accepted before edge N is visible after edge N+1 and
    // leaves in order; two items in flight fill both stages.
    always @(negedge clk) begin
        logic exp_ready;
        logic exp_valid;
        if (!arst_ni) begin
            q.delete();
            mcnt = '0;
        end else begin
            exp_ready = !flush && (q.size() < 2 || bus.out_ready);
            exp_valid = !flush && q.size() > 0 && cyc >= q[0].stamp + 2;
            check("in_ready", bus.in_ready, exp_ready);
            check("out_valid", bus.out_valid, exp_valid);
            check("txn_count", bus.txn_count, mcnt);
            if (exp_valid && bus.out_valid) begin
                check("opa", bus.opa, 8'(q[0].p.sum - q[0].p.opb));
                check("borrow", bus.borrow, q[0].p.sum < q[0].p.opb);
            end
            if (bus.out_valid && bus.out_ready) begin
                out_seen++;
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
            end
            if (bus.in_valid && bus.in_ready) in_seen++;
            if (bus.in_valid && !bus.in_ready) ready_drops++;
            if (flush) begin
                q.delete();
            end else begin
                if (exp_valid && bus.out_ready) begin
                    void'(q.pop_front());
                    mcnt = mcnt + 1'b1;
                end
                if (bus.in_valid && exp_ready) begin
                    q.push_back('{p: '{sum: bus.sum, opb: bus.opb}, stamp: cyc});
                end
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] s, input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.sum      = s;
        bus.opb      = b;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic clear_track();
        out_seen    = 0;
        first_out   = -1;
        last_out    = -1;
        ready_drops = 0;
        in_seen     = 0;
    endtask

    task automatic wait_out(input logic [7:0] eo, input logic eb, input string nm);
        int n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s: out_valid not seen within 20 cycles", nm);
        end else begin
            check({nm, "_opa"}, bus.opa, eo);
            check({nm, "_borrow"}, bus.borrow, eb);
        end
    endtask

    initial begin
        int i;
        logic [CW-1:0] cnt_before;

        arst_ni       = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.sum       = '0;
        bus.opb       = '0;
        bus.out_ready = 1'b0;
        #2;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_opa", bus.opa, 0);
        check("rst_borrow", bus.borrow, 0);
        check("rst_txn", bus.txn_count, 0);
        #11 arst_ni = 1'b1;
        #1 check("rst_in_ready", bus.in_ready, 1);
        tick();

        // basic
        bus.out_ready = 1'b1;
        put(8'h0A, 8'h03);
        tick();
        idle();
        wait_out(8'h07, 1'b0, "basic");
        @(negedge clk);
        check("basic_txn", bus.txn_count, 1);
        tick();

        // wrap cases
        put(8'h02, 8'h05);
        tick();
        put(8'hFF, 8'hFF);
        tick();
        idle();
        wait_out(8'hFD, 1'b1, "wrap1");
        @(negedge clk);
        check("wrap2_valid", bus.out_valid, 1);
        check("wrap2_opa", bus.opa, 8'h00);
        check("wrap2_borrow", bus.borrow, 0);
        tick();
        repeat (3) tick();

        // back-to-back
        clear_track();
        for (int k = 0; k < 16; k++) begin
            put(8'(k), 8'h01);
            tick();
        end
        idle();
        repeat (6) tick();
        check("b2b_outputs", out_seen, 16);
        check("b2b_span", last_out - first_out, 15);
        check("b2b_ready_drops", ready_drops, 0);

        // backpressure
        clear_track();
        bus.out_ready = 1'b0;
        i = 0;
        for (int c = 0; c < 5; c++) begin
            put(8'(8'h20 + i), 8'h10);
            @(negedge clk);
            if (bus.in_ready) i++;
            if (c == 4) begin
                check("bp_opa_hold", bus.opa, 8'h10);
                check("bp_in_ready", bus.in_ready, 0);
            end
            tick();
        end
        check("bp_accepted", in_seen, 2);
        bus.out_ready = 1'b1;
        for (int g = 0; g < 20 && i < 4; g++) begin
            put(8'(8'h20 + i), 8'h10);
            @(negedge clk);
            if (bus.in_ready) i++;
            tick();
        end
        idle();
        repeat (6) tick();
        check("bp_drained", out_seen, 4);

        // flush
        bus.out_ready = 1'b0;
        put(8'h30, 8'h01);
        tick();
        put(8'h31, 8'h01);
        tick();
        cnt_before = mcnt;
        clear_track();
        flush = 1'b1;
        put(8'h32, 8'h01);
        tick();
        flush = 1'b0;
        idle();
        @(negedge clk);
        check("flush_out_valid", bus.out_valid, 0);
        check("flush_txn", bus.txn_count, cnt_before);
        bus.out_ready = 1'b1;
        repeat (5) tick();
        check("flush_no_leak", out_seen, 0);

        // reset mid-stream
        bus.out_ready = 1'b0;
        put(8'h40, 8'h02);
        tick();
        put(8'h41, 8'h02);
        tick();
        idle();
        tick();
        #2 arst_ni = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_opa", bus.opa, 0);
        check("mid_rst_borrow", bus.borrow, 0);
        check("mid_rst_txn", bus.txn_count, 0);
        @(posedge clk);
        #3 arst_ni = 1'b1;
        tick();

        // counter wrap
        bus.out_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            put(8'(k + 3), 8'(k));
            tick();
        end
        idle();
        repeat (5) tick();
        @(negedge clk);
        check("cnt_wrap", bus.txn_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
